shuffle_aes_sched: RTL and testbench
====================================

// Module: shuffle_aes_sched
// PURPOSE
// Round-robin scheduler that shares one pipelined shuffle AES datapath (fixed latency, no stall) among
// NUM_REQ hash lanes. Accepts one (block,key) pair per cycle. Tags each issue with its lane and steers
// the AES output back to that lane after the pipeline latency. At most one operation is in flight per lane.
// Sits between the per-lane shuffle/scratchpad sequencers and the AES wrapper.
// PARAMETERS
// NUM_REQ  4   number of requesting lanes (>=2)
// AES_LAT  4   clock cycles from aes_in/aes_key valid to matching aes_out (>=1)
// CNT_W    32  width of issue counter
// PORTS
// clk        in   1             clock; all logic rising-edge
// rst        in   1             synchronous reset, active-high
// req_valid  in   NUM_REQ       lane i has a (block,key) pair ready
// req_ready  out  NUM_REQ       one-hot grant; transfer when req_valid[i]&req_ready[i]
// req_in     in   NUM_REQ*128   lane i block at [128*i+:128]
// req_key    in   NUM_REQ*128   lane i round key at [128*i+:128]
// aes_in     out  128           registered block to AES datapath
// aes_key    out  128           registered key to AES datapath
// aes_out    in   128           AES result, AES_LAT cycles after aes_in
// rsp_valid  out  NUM_REQ       one-hot, 1-cycle pulse: rsp_data belongs to lane i
// rsp_data   out  128           registered AES result
// lane_busy  out  NUM_REQ       lane has an operation in flight
// issue_cnt  out  CNT_W         total accepted requests; wraps modulo 2^CNT_W
// BEHAVIOUR
// - Reset values: req_ready=0, aes_in=0, aes_key=0, rsp_valid=0, rsp_data=0, lane_busy=0, issue_cnt=0.
//   The round-robin pointer resets to NUM_REQ-1, so lane 0 has first priority.
// - Eligibility: elig[i] = req_valid[i] & ~lane_busy[i]. lane_busy is the registered value.
// - Arbitration (combinational): req_ready = one-hot of the first eligible lane, searching ptr+1, ptr+2, ...
//   with modulo NUM_REQ wrap. req_ready=0 if no lane is eligible. req_ready may depend on req_valid.
//   A lane must hold req_valid and its data stable until its grant.
// - On grant of lane g in cycle T:
//   ptr<=g; aes_in<=req_in[g]; aes_key<=req_key[g]; lane_busy[g]<=1; issue_cnt<=issue_cnt+1.
// - aes_in/aes_key hold their last value when there is no grant (don't-care, untagged).
// - Tag pipeline: AES_LAT-deep shift register of {vld,lane} aligned with the datapath.
//   Stage 0 is loaded at T+1 together with aes_in. The tail pairs with aes_out in cycle T+1+AES_LAT.
// - Response: when the tail vld=1, in that same cycle:
//   rsp_data<=aes_out; rsp_valid<=onehot(lane); lane_busy[lane]<=0.
//   Result: rsp_valid pulses in cycle T+AES_LAT+2, and lane_busy clears in that cycle.
//   Otherwise rsp_valid<=0 and rsp_data holds.
// - Response path has no backpressure: consumers must sample on the rsp_valid pulse.
// - Simultaneous events:
//   (a) Response for lane i and new req_valid[i] in the same cycle: not granted.
//       lane i becomes eligible the next cycle, when lane_busy is 0.
//   (b) Grant of lane j and response of lane k in the same cycle: both take effect (j!=k, guaranteed by busy).
// - Throughput: one issue per cycle while distinct lanes are eligible. Per-lane rate is 1 per AES_LAT+2 cycles.
// - Fairness: a continuously eligible lane is granted within NUM_REQ grants.
// - issue_cnt wraps from 2^CNT_W-1 to 0 silently.
// - Reset mid-operation clears the tag pipeline, busy, rsp and ptr. Results still inside the AES datapath are
//   dropped: no rsp_valid is asserted for them after reset.
// TESTING
// - Single req: lane 2 valid at cycle 5 -> req_ready=4'b0100 at 5; aes_in=req_in[2] at 6;
//   rsp_valid=4'b0100 at 5+AES_LAT+2=11 with rsp_data=aes_out sampled at 10.
// - All 4 lanes valid from reset -> grants 0,1,2,3 in cycles 1..4.
//   No grant again until each lane's rsp. Responses return in order 0,1,2,3, one per cycle.
// - Lane 1 re-requests on its rsp cycle -> not granted that cycle, granted the next (lane_busy[1]=0).
// - Lanes 0 and 3 permanently valid, ptr=0 -> grant 3 then 0 alternately as busy allows.
//   No lane starves across 1000 cycles.
// - rst=1 for one cycle while 3 ops are in flight -> all outputs zero next cycle.
//   No rsp_valid during the following 2*AES_LAT cycles.
// - Force issue_cnt to 2^CNT_W-1 (CNT_W=4 build), one grant -> issue_cnt=0.

Source files
------------

// File: rtl/shuffle_aes_sched_if.sv
// Bus bundle between the per-lane sequencers, the round-robin scheduler and the shared AES datapath.
// Request handshake: lane i transfers when req_valid[i] & req_ready[i]; req_valid and data hold until granted.
interface shuffle_aes_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 32
);
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*128-1:0] req_in;
   logic [NUM_REQ*128-1:0] req_key;
   logic [127:0]           aes_in;
   logic [127:0]           aes_key;
   logic [127:0]           aes_out;
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [127:0]           rsp_data;
   logic [NUM_REQ-1:0]     lane_busy;
   logic [CNT_W-1:0]       issue_cnt;

   modport slave (
      input  req_valid, req_in, req_key, aes_out,
      output req_ready, aes_in, aes_key, rsp_valid, rsp_data, lane_busy, issue_cnt
   );

   modport master (
      output req_valid, req_in, req_key, aes_out,
      input  req_ready, aes_in, aes_key, rsp_valid, rsp_data, lane_busy, issue_cnt
   );
endinterface

// File: rtl/shuffle_aes_sched.sv
// Round-robin scheduler sharing one fixed-latency AES pipeline among NUM_REQ lanes,
// tagging each issue with its lane and steering the result back after AES_LAT cycles.
module shuffle_aes_sched #(
   parameter int NUM_REQ = 4,
   parameter int AES_LAT = 4,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   shuffle_aes_sched_if.slave bus
);
   localparam int PTR_W = $clog2(NUM_REQ);

   typedef struct packed {
      logic             vld;
      logic [PTR_W-1:0] lane;
   } tag_t;

   logic [PTR_W-1:0]   r_ptr;
   logic [127:0]       r_aes_in;
   logic [127:0]       r_aes_key;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [127:0]       r_rsp_data;
   logic [NUM_REQ-1:0] r_lane_busy;
   logic [CNT_W-1:0]   r_issue_cnt;
   // Stage 0 tags the aes_in register; stages 1..AES_LAT follow the datapath to aes_out.
   tag_t               r_tag [0:AES_LAT];

   logic [NUM_REQ-1:0] w_elig;
   logic               w_grant_vld;
   logic [PTR_W-1:0]   w_grant_idx;
   logic [NUM_REQ-1:0] w_grant;
   logic [NUM_REQ-1:0] w_busy_nxt;
   logic [NUM_REQ-1:0] w_rsp_onehot;
   tag_t               w_tail;
   int                 w_idx;

   assign w_elig       = bus.req_valid & ~r_lane_busy;
   assign w_tail       = r_tag[AES_LAT];
   assign w_rsp_onehot = NUM_REQ'(1) << w_tail.lane;

   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      w_idx       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = (int'(r_ptr) + k) % NUM_REQ;
         if (!w_grant_vld && w_elig[w_idx]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = PTR_W'(w_idx);
         end
      end
   end

   assign w_grant = w_grant_vld ? (NUM_REQ'(1) << w_grant_idx) : '0;

   // Granted and retiring lanes never coincide, so set and clear cannot collide.
   always_comb begin
      w_busy_nxt = r_lane_busy;
      if (w_tail.vld) begin
         w_busy_nxt = w_busy_nxt & ~w_rsp_onehot;
      end
      w_busy_nxt = w_busy_nxt | w_grant;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= PTR_W'(NUM_REQ - 1);
         r_aes_in    <= '0;
         r_aes_key   <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_lane_busy <= '0;
         r_issue_cnt <= '0;
         for (int i = 0; i <= AES_LAT; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         if (w_grant_vld) begin
            r_ptr       <= w_grant_idx;
            r_aes_in    <= bus.req_in[128*w_grant_idx +: 128];
            r_aes_key   <= bus.req_key[128*w_grant_idx +: 128];
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
         end
         r_tag[0].vld  <= w_grant_vld;
         r_tag[0].lane <= w_grant_idx;
         for (int i = 1; i <= AES_LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
         r_lane_busy <= w_busy_nxt;
         if (w_tail.vld) begin
            r_rsp_data  <= bus.aes_out;
            r_rsp_valid <= w_rsp_onehot;
         end else begin
            r_rsp_valid <= '0;
         end
      end
   end

   assign bus.req_ready = w_grant;
   assign bus.aes_in    = r_aes_in;
   assign bus.aes_key   = r_aes_key;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.lane_busy = r_lane_busy;
   assign bus.issue_cnt = r_issue_cnt;
endmodule

// File: tb/tb_shuffle_aes_sched.sv
// Directed bench for shuffle_aes_sched: arbitration order, latency, busy handling, reset flush, counter wrap.
module tb_shuffle_aes_sched;
   localparam int NUM_REQ = 4;
   localparam int AES_LAT = 4;
   localparam int CNT_W   = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   shuffle_aes_sched_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

   shuffle_aes_sched #(.NUM_REQ(NUM_REQ), .AES_LAT(AES_LAT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] aes_f(input logic [127:0] x, input logic [127:0] k);
      return {x[63:0], x[127:64]} ^ k ^ 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
   endfunction

   function automatic logic [127:0] mk_blk(input int lane, input int seq);
      return {32'hB10C_0000 + 32'(lane), 32'(seq), 32'hCAFE_0000 + 32'(lane * 16 + seq), 32'h0123_4567 ^ 32'(seq)};
   endfunction

   function automatic logic [127:0] mk_key(input int lane, input int seq);
      return {32'hEE00_0000 + 32'(seq), 32'h7777_0000 + 32'(lane), 32'h89AB_CDEF, 32'h0000_1000 * 32'(lane + 1)};
   endfunction

   // AES stand-in: fixed AES_LAT-cycle pipeline, no reset, so stale results survive a scheduler reset.
   logic [127:0] m_pipe [AES_LAT];
   always @(posedge clk) begin
      m_pipe[0] <= aes_f(bus.aes_in, bus.aes_key);
      for (int i = 1; i < AES_LAT; i++) m_pipe[i] <= m_pipe[i-1];
   end
   assign bus.aes_out = m_pipe[AES_LAT-1];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_lane(input int i, input logic [127:0] b, input logic [127:0] k);
      bus.req_in[128*i +: 128]  = b;
      bus.req_key[128*i +: 128] = k;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
      checks++; if (bus.aes_in !== 128'd0) begin errors++; $display("FAIL reset_aes_in: got %h expected 0", bus.aes_in); end
      checks++; if (bus.aes_key !== 128'd0) begin errors++; $display("FAIL reset_aes_key: got %h expected 0", bus.aes_key); end
      checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 128'd0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
      checks++; if (bus.lane_busy !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b expected 0000", bus.lane_busy); end
      checks++; if (bus.issue_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.issue_cnt); end
   endtask

   task automatic test_single();
      int n;
      logic [127:0] b;
      logic [127:0] k;
      pulse_reset();
      b = mk_blk(2, 0);
      k = mk_key(2, 0);
      set_lane(2, b, k);
      bus.req_valid = 4'b0100;
      #1;
      checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = '0;
      checks++; if (bus.aes_in !== b) begin errors++; $display("FAIL single_aes_in: got %h expected %h", bus.aes_in, b); end
      checks++; if (bus.aes_key !== k) begin errors++; $display("FAIL single_aes_key: got %h expected %h", bus.aes_key, k); end
      checks++; if (bus.lane_busy !== 4'b0100) begin errors++; $display("FAIL single_busy: got %b expected 0100", bus.lane_busy); end
      checks++; if (bus.issue_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", bus.issue_cnt); end
      n = 1;
      while (bus.rsp_valid === 4'b0000 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n != AES_LAT + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", n, AES_LAT + 2); end
      checks++; if (bus.rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0100", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== aes_f(b, k)) begin errors++; $display("FAIL single_rsp_data: got %h expected %h", bus.rsp_data, aes_f(b, k)); end
      checks++; if (bus.lane_busy !== 4'b0000) begin errors++; $display("FAIL single_busy_clear: got %b expected 0000", bus.lane_busy); end
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_pulse: got %b expected 0000", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== aes_f(b, k)) begin errors++; $display("FAIL single_rsp_hold: got %h expected %h", bus.rsp_data, aes_f(b, k)); end
   endtask

   task automatic test_all_lanes();
      logic [3:0] er_ready [10];
      logic [3:0] er_rsp [10];
      er_ready = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      er_rsp   = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      pulse_reset();
      for (int i = 0; i < NUM_REQ; i++) set_lane(i, mk_blk(i, 1), mk_key(i, 1));
      bus.req_valid = 4'b1111;
      #1;
      for (int c = 0; c < 10; c++) begin
         checks++; if (bus.req_ready !== er_ready[c]) begin errors++; $display("FAIL all_ready c%0d: got %b expected %b", c, bus.req_ready, er_ready[c]); end
         checks++; if (bus.rsp_valid !== er_rsp[c]) begin errors++; $display("FAIL all_rsp c%0d: got %b expected %b", c, bus.rsp_valid, er_rsp[c]); end
         if (c >= 6) begin
            checks++;
            if (bus.rsp_data !== aes_f(mk_blk(c - 6, 1), mk_key(c - 6, 1))) begin
               errors++; $display("FAIL all_rsp_data c%0d: got %h expected %h", c, bus.rsp_data, aes_f(mk_blk(c - 6, 1), mk_key(c - 6, 1)));
            end
         end
         @(negedge clk);
      end
      bus.req_valid = '0;
      repeat (8) @(negedge clk);
      checks++; if (bus.issue_cnt !== 4'd8) begin errors++; $display("FAIL all_cnt: got %0d expected 8", bus.issue_cnt); end
      checks++; if (bus.lane_busy !== 4'b0000) begin errors++; $display("FAIL all_drain: got %b expected 0000", bus.lane_busy); end
   endtask

   task automatic test_rerequest();
      set_lane(1, mk_blk(1, 2), mk_key(1, 2));
      bus.req_valid = 4'b0010;
      #1;
      checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rereq_first: got %b expected 0010", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = '0;
      repeat (4) @(negedge clk);
      set_lane(1, mk_blk(1, 3), mk_key(1, 3));
      bus.req_valid = 4'b0010;
      #1;
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rereq_blocked: got %b expected 0000", bus.req_ready); end
      checks++; if (bus.lane_busy !== 4'b0010) begin errors++; $display("FAIL rereq_busy: got %b expected 0010", bus.lane_busy); end
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rereq_grant: got %b expected 0010", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL rereq_rsp: got %b expected 0010", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== aes_f(mk_blk(1, 2), mk_key(1, 2))) begin errors++; $display("FAIL rereq_data: got %h expected %h", bus.rsp_data, aes_f(mk_blk(1, 2), mk_key(1, 2))); end
      @(negedge clk);
      bus.req_valid = '0;
      checks++; if (bus.aes_in !== mk_blk(1, 3)) begin errors++; $display("FAIL rereq_aes_in: got %h expected %h", bus.aes_in, mk_blk(1, 3)); end
      checks++; if (bus.lane_busy !== 4'b0010) begin errors++; $display("FAIL rereq_busy_again: got %b expected 0010", bus.lane_busy); end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_fairness();
      int last;
      int lane;
      int cnt [2];
      int prev [2];
      set_lane(0, mk_blk(0, 4), mk_key(0, 4));
      set_lane(3, mk_blk(3, 4), mk_key(3, 4));
      bus.req_valid = 4'b0001;
      #1;
      checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL fair_seed: got %b expected 0001", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 4'b1001;
      last = 0;
      cnt = '{0, 0};
      prev = '{0, -1};
      for (int c = 1; c <= 1000; c++) begin
         #1;
         if (bus.req_ready !== 4'b0000) begin
            lane = (bus.req_ready === 4'b0001) ? 0 : (bus.req_ready === 4'b1000) ? 3 : 99;
            checks++; if (lane == 99) begin errors++; $display("FAIL fair_onehot c%0d: got %b expected 0001 or 1000", c, bus.req_ready); end
            checks++; if (lane == last) begin errors++; $display("FAIL fair_alternate c%0d: got lane %0d expected the other lane", c, lane); end
            if (lane != 99) begin
               if (prev[lane / 3] >= 0) begin
                  checks++;
                  if (c - prev[lane / 3] != AES_LAT + 2) begin
                     errors++; $display("FAIL fair_rate c%0d: got gap %0d expected %0d", c, c - prev[lane / 3], AES_LAT + 2);
                  end
               end
               prev[lane / 3] = c;
               cnt[lane / 3]++;
            end
            last = lane;
         end
         @(negedge clk);
      end
      bus.req_valid = '0;
      checks++; if (cnt[0] < 160) begin errors++; $display("FAIL fair_lane0: got %0d grants expected at least 160", cnt[0]); end
      checks++; if (cnt[1] < 160) begin errors++; $display("FAIL fair_lane3: got %0d grants expected at least 160", cnt[1]); end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n;
      for (int i = 0; i < 3; i++) set_lane(i, mk_blk(i, 5), mk_key(i, 5));
      bus.req_valid = 4'b0111;
      n = 0;
      @(negedge clk);
      while (bus.lane_busy !== 4'b0111 && n < 10) begin
         @(negedge clk);
         n++;
      end
      bus.req_valid = '0;
      checks++; if (bus.lane_busy !== 4'b0111) begin errors++; $display("FAIL rstmid_inflight: got %b expected 0111", bus.lane_busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.lane_busy !== 4'b0000) begin errors++; $display("FAIL rstmid_busy: got %b expected 0000", bus.lane_busy); end
      checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_rsp: got %b expected 0000", bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 128'd0) begin errors++; $display("FAIL rstmid_rsp_data: got %h expected 0", bus.rsp_data); end
      checks++; if (bus.aes_in !== 128'd0) begin errors++; $display("FAIL rstmid_aes_in: got %h expected 0", bus.aes_in); end
      checks++; if (bus.issue_cnt !== 4'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d expected 0", bus.issue_cnt); end
      for (int c = 0; c < 2 * AES_LAT; c++) begin
         @(negedge clk);
         checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_drop c%0d: got %b expected 0000", c, bus.rsp_valid); end
      end
      bus.req_valid = 4'b0011;
      #1;
      checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr: got %b expected 0001", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = '0;
      checks++; if (bus.issue_cnt !== 4'd1) begin errors++; $display("FAIL rstmid_cnt_after: got %0d expected 1", bus.issue_cnt); end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_wrap();
      int g;
      int n;
      pulse_reset();
      for (int i = 0; i < NUM_REQ; i++) set_lane(i, mk_blk(i, 6), mk_key(i, 6));
      bus.req_valid = 4'b1111;
      g = 0;
      n = 0;
      while (g < 15 && n < 60) begin
         #1;
         if (bus.req_ready !== 4'b0000) g++;
         @(negedge clk);
         n++;
      end
      bus.req_valid = '0;
      checks++; if (g != 15) begin errors++; $display("FAIL wrap_grants: got %0d expected 15", g); end
      repeat (8) @(negedge clk);
      checks++; if (bus.issue_cnt !== 4'hF) begin errors++; $display("FAIL wrap_max: got %0d expected 15", bus.issue_cnt); end
      set_lane(2, mk_blk(2, 7), mk_key(2, 7));
      bus.req_valid = 4'b0100;
      #1;
      checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ready: got %b expected 0100", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = '0;
      checks++; if (bus.issue_cnt !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", bus.issue_cnt); end
      checks++; if (bus.aes_in !== mk_blk(2, 7)) begin errors++; $display("FAIL wrap_aes_in: got %h expected %h", bus.aes_in, mk_blk(2, 7)); end
      repeat (8) @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_in = '0;
      bus.req_key = '0;
      test_reset();
      test_single();
      test_all_lanes();
      test_rerequest();
      test_fairness();
      test_reset_mid();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
